serializer: RTL



---
 rtl/serdes_pkg.sv | 8 +
 rtl/bit_tick_gen.sv | 18 +
 rtl/serializer.sv | 102 ++++++++++
 3 files changed

// File: rtl/serdes_pkg.sv
// serdes_pkg: FSM states, preamble constants and default link parameters shared by the serializer and deserializer
package serdes_pkg;
  typedef enum logic [2:0] {IDLE, PRE, DATA, PAR, GAP} state_t;
  localparam int PREAMBLE_BITS = 2;
  localparam logic [1:0] PREAMBLE_VAL = 2'b11;
  localparam int DATA_W_DEF = 32;
  localparam int DIV_DEF = 8;
endpackage

// File: rtl/bit_tick_gen.sv
// bit_tick_gen: divide-by-DIV counter with sync clear, one-cycle tick on the last cycle of each bit
module bit_tick_gen
  import serdes_pkg::*;
#(
  parameter int DIV = DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
  logic [CW-1:0] cnt;
  assign tick = cnt == CW'(DIV - 1);
  // count cycles within a bit, wrapping at the boundary; clear realigns bits to a new frame
  always_ff @(posedge clk)
    cnt <= (rst || clr || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/serializer.sv
// serializer: framed parallel-to-serial transmitter (preamble 11, data MSB-first, idle gap); SERIALIZER_PARITY_EN adds an even-parity bit after the data
module serializer
  import serdes_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int DIV       = DIV_DEF,
  parameter int IDLE_BITS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx_out,
  output logic              busy,
  output logic              frame_done
);
  localparam int BW = $clog2(DATA_W + IDLE_BITS + PREAMBLE_BITS);
  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [BW-1:0]     bit_cnt;
  logic              tick;
  logic              accept;
  logic              last_bit;
`ifdef SERIALIZER_PARITY_EN
  logic              par;
`endif
  assign accept     = in_valid && in_ready;
  assign last_bit   = bit_cnt == BW'(state == PRE ? PREAMBLE_BITS - 1 : state == DATA ? DATA_W - 1 : IDLE_BITS - 1);
  assign frame_done = state == GAP && tick && last_bit;
  bit_tick_gen #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .tick (tick)
  );
  // frame FSM; tx_out is loaded with the next bit's level at each bit boundary so it stays registered
  always_ff @(posedge clk)
    if (rst) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      tx_out   <= 1'b0;
      busy     <= 1'b0;
      in_ready <= 1'b1;
`ifdef SERIALIZER_PARITY_EN
      par      <= 1'b0;
`endif
    end else
      case (state)
        IDLE: if (accept) begin
          state    <= PRE;
          shreg    <= in_data;
          bit_cnt  <= '0;
          tx_out   <= PREAMBLE_VAL[1];
          busy     <= 1'b1;
          in_ready <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
          par      <= ^in_data;
`endif
        end
        PRE: if (tick) begin
          state   <= last_bit ? DATA : PRE;
          bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
          tx_out  <= last_bit ? shreg[DATA_W-1] : PREAMBLE_VAL[0];
        end
        DATA: if (tick) begin
          if (last_bit) begin
            bit_cnt <= '0;
`ifdef SERIALIZER_PARITY_EN
            state   <= PAR;
            tx_out  <= par;
`else
            state   <= GAP;
            tx_out  <= 1'b0;
`endif
          end else begin
            shreg   <= {shreg[DATA_W-2:0], 1'b0};
            bit_cnt <= bit_cnt + 1'b1;
            tx_out  <= shreg[DATA_W-2];
          end
        end
`ifdef SERIALIZER_PARITY_EN
        PAR: if (tick) begin
          state  <= GAP;
          tx_out <= 1'b0;
        end
`endif
        GAP: if (tick) begin
          state    <= last_bit ? IDLE : GAP;
          bit_cnt  <= last_bit ? '0 : bit_cnt + 1'b1;
          busy     <= !last_bit;
          in_ready <= last_bit;
        end
        default: begin
          state    <= IDLE;
          tx_out   <= 1'b0;
          busy     <= 1'b0;
          in_ready <= 1'b1;
        end
      endcase
endmodule
